if_stage: RTL

- Fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the IF/ID pipeline register and produces instr_fetch/pc_fetch for it.
- Owns the PC register and drives a request/ready instruction-memory port that supports a variable number of wait states.
- Applies hazard-unit stalls and EX-stage branch/jump redirects.
- Emits a NOP (all-zero instruction) whenever no valid instruction is available, so IF/ID captures a bubble.

---
 rtl/if_stage_pkg.sv | 21 ++
 rtl/if_stage_if.sv | 45 ++++
 rtl/if_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package if_stage_pkg;

    localparam int          IF_WIDTH    = 32;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
    localparam int          IF_PC_INC   = 4;

    // FETCH: request in flight at pc. HOLD: instruction parked while the
    // hazard unit stalls. DRAIN: request must complete but its data is dropped.
    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_HOLD  = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;

    // Only HOLD leaves the memory port idle.
    function automatic logic issues_request(if_state_e s);
        return s != IF_HOLD;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its environment.
//
// Memory handshake: imem_req/imem_addr are driven by the fetch stage; the
// transfer completes in any cycle where imem_req=1 and imem_ready=1, and
// imem_rdata is valid in that same cycle. Once raised, imem_req stays high
// and imem_addr stays stable until imem_ready (except across reset, which
// abandons the request). The memory should not assert imem_ready while
// imem_req=0.
interface if_stage_if #(parameter int WIDTH = 32);

    logic             stall_fetch;
    logic             redirect_en;
    logic [WIDTH-1:0] redirect_pc;

    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ready;
    logic [WIDTH-1:0] imem_rdata;

    logic [WIDTH-1:0] instr_fetch;
    logic [WIDTH-1:0] pc_fetch;
    logic             fetch_valid;

    // Current FSM state, exposed for observation.
    logic [1:0]       dbg_state;

    // Fetch stage side.
    modport slave (
        input  stall_fetch, redirect_en, redirect_pc,
        input  imem_ready, imem_rdata,
        output imem_req, imem_addr,
        output instr_fetch, pc_fetch, fetch_valid,
        output dbg_state
    );

    // Pipeline control / memory side.
    modport master (
        output stall_fetch, redirect_en, redirect_pc,
        output imem_ready, imem_rdata,
        input  imem_req, imem_addr,
        input  instr_fetch, pc_fetch, fetch_valid,
        input  dbg_state
    );

endinterface

// File: rtl/if_stage.sv
// MIPS fetch stage: owns the PC, issues instruction-memory requests with
// variable wait states, honours hazard stalls and EX-stage redirects, and
// presents a NOP to IF/ID whenever no real instruction is available.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int               WIDTH    = IF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = IF_RESET_PC[WIDTH-1:0],
    parameter int               PC_INC   = IF_PC_INC
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.slave   bus
);

    if_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] ibuf_q, ibuf_d;

    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             fetch_valid;
    logic [WIDTH-1:0] instr_fetch;
    logic [WIDTH-1:0] pc_fetch;

    // Every value loaded into pc is word aligned.
    function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] a);
        return {a[WIDTH-1:2], 2'b00};
    endfunction

    // Next-state logic; redirects take priority over stalls everywhere.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        ibuf_d  = ibuf_q;
        case (state_q)
            IF_FETCH: begin
                if (bus.redirect_en && bus.imem_ready) begin
                    // Response arrives with the redirect: drop it.
                    pc_d = word_align(bus.redirect_pc);
                end else if (bus.redirect_en) begin
                    // Request still pending; it must finish at the old address.
                    tgt_d   = bus.redirect_pc;
                    state_d = IF_DRAIN;
                end else if (bus.imem_ready && !bus.stall_fetch) begin
                    pc_d = word_align(pc_q + WIDTH'(PC_INC));
                end else if (bus.imem_ready) begin
                    ibuf_d  = bus.imem_rdata;
                    state_d = IF_HOLD;
                end
            end
            IF_HOLD: begin
                if (bus.redirect_en) begin
                    pc_d    = word_align(bus.redirect_pc);
                    state_d = IF_FETCH;
                end else if (!bus.stall_fetch) begin
                    pc_d    = word_align(pc_q + WIDTH'(PC_INC));
                    state_d = IF_FETCH;
                end
            end
            IF_DRAIN: begin
                // The most recent redirect is the one that counts.
                if (bus.redirect_en) begin
                    tgt_d = bus.redirect_pc;
                end
                if (bus.imem_ready) begin
                    pc_d    = word_align(bus.redirect_en ? bus.redirect_pc : tgt_q);
                    state_d = IF_FETCH;
                end
            end
            default: begin
                state_d = IF_FETCH;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IF_FETCH;
            pc_q    <= word_align(RESET_PC);
            tgt_q   <= '0;
            ibuf_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            ibuf_q  <= ibuf_d;
        end
    end

    // Outputs: zero-latency pass-through of memory data in FETCH, parked
    // instruction in HOLD, bubble otherwise.
    always_comb begin
        imem_req    = issues_request(state_q);
        imem_addr   = pc_q;
        fetch_valid = 1'b0;
        instr_fetch = '0;
        pc_fetch    = pc_q;
        case (state_q)
            IF_FETCH: begin
                if (bus.imem_ready && !bus.redirect_en) begin
                    fetch_valid = 1'b1;
                    instr_fetch = bus.imem_rdata;
                end
            end
            IF_HOLD: begin
                fetch_valid = 1'b1;
                instr_fetch = ibuf_q;
            end
            default: begin
                fetch_valid = 1'b0;
            end
        endcase
    end

    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = imem_addr;
    assign bus.fetch_valid = fetch_valid;
    assign bus.instr_fetch = instr_fetch;
    assign bus.pc_fetch    = pc_fetch;
    assign bus.dbg_state   = state_q;

endmodule
